mmio_arbiter: RTL and testbench
===============================

# mmio_arbiter

Two-requester arbiter for the shared memory-mapped I/O bus that reaches SPART, VGA, codec and button registers. Requesters are the processor's I/O port (CPU) and a DMA/refill engine (DMA). The block grants one requester at a time using fair round-robin and drives a single device-side transaction. A watchdog terminates any device access that never acknowledges.

## Interface
Parameters:
- `DATA_W`, 24: data width.
- `ADDR_W`, 24: address width.
- `TIMEOUT`, 15: maximum cycles the arbiter waits for `dev_ack`. Legal range is 1..255.

Ports:
- `clk`  in  1  system clock. Everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_en`  in  1  CPU request, level-sensitive. The CPU holds it and its fields stable until `cpu_ack`.
- `cpu_iorw`  in  1  1 = read (load), 0 = write (store).
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdata`  out  DATA_W  CPU read data, valid with `cpu_ack`.
- `cpu_ack`  out  1  one-cycle completion pulse to the CPU.
- `dma_en`, `dma_iorw`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same set of signals for the DMA requester.
- `dev_en`  out  1  device strobe, held high until the device acks or the timeout fires.
- `dev_iorw`  out  1  device direction.
- `dev_addr`  out  ADDR_W  device address.
- `dev_wdata`  out  DATA_W  device write data.
- `dev_rdata`  in  DATA_W  device read data, sampled when `dev_ack` = 1.
- `dev_ack`  in  1  device completion.
- `owner`  out  1  0 = CPU, 1 = DMA. Valid while `busy` = 1.
- `busy`  out  1  high from grant through the DONE state.
- `timeout_err`  out  1  one-cycle pulse when a transaction times out.

## Operation
- States:
  - IDLE: no transaction.
  - WAIT: `dev_en` high.
  - DONE: one cycle after completion. Requests are ignored, so a requester dropping `*_en` after its ack is never re-granted.
- IDLE, exactly one requester active: grant it.
- IDLE, both requesters active: grant the one that is not `last_owner`.
  - `last_owner` resets to DMA, so the CPU wins the first tie.
- On grant:
  - Register the winner's iorw, addr and wdata onto the `dev_*` outputs.
  - Set `owner` and `last_owner`.
  - Clear the timeout counter and go to WAIT.
- WAIT, `dev_ack` = 1:
  - Drop `dev_en`.
  - Pulse the owner's `*_ack`.
  - On a read, load the owner's `*_rdata` from `dev_rdata`. On a write, `*_rdata` keeps its previous value.
  - Go to DONE.
- WAIT, no ack, counter = TIMEOUT−1:
  - Drop `dev_en`.
  - Pulse the owner's `*_ack` and `timeout_err`.
  - On a read, the owner's `*_rdata` becomes all ones.
  - Go to DONE.
- WAIT, otherwise: increment the counter.
- DONE → IDLE unconditionally.
- `dev_ack` in IDLE or DONE is ignored and has no side effects.
- The non-owner's `*_ack` is never asserted. Its request stays pending with no timeout on the requester side.
- Reset values:
  - All outputs 0, including `owner`, `busy`, both rdata registers and all `dev_*` outputs.
  - State IDLE, counter 0, `last_owner` = DMA.
- Reset during WAIT abandons the transaction. No ack and no `timeout_err` are issued.

## Timing
- Request high at edge k while in IDLE → `dev_en`, `busy` and the `dev_*` fields are valid from cycle k+1.
- `dev_ack` sampled at edge m → `*_ack` and `*_rdata` valid during cycle m+1, `dev_en` = 0 in m+1, IDLE at m+2.
- Minimum access is 3 cycles (grant, ack, done). The earliest next grant is sampled at edge m+2, giving `dev_en` at m+3.
- A device that never acks: `dev_en` is high for exactly TIMEOUT cycles. `timeout_err` and `*_ack` then pulse together in the following cycle.
- `dev_ack` coinciding with the final timeout cycle counts as a normal completion. `timeout_err` stays 0.

## Structure
- Package `mmio_arb_pkg` holds:
  - the state enum {IDLE, WAIT, DONE};
  - owner constants `OWN_CPU` = 0 and `OWN_DMA` = 1;
  - the `ERR_DATA` all-ones constant;
  - the default TIMEOUT.
- Sub-module `rr_pick2`: a combinational two-way round-robin picker with inputs req[1:0] and last, and output the winner. It is instantiated once.
- The counter width is 8 bits.

## Test plan
- CPU read at 0x00000C; device acks after 2 cycles with 0x8A4F1B → `cpu_ack` pulses once with `cpu_rdata` = 0x8A4F1B. `dma_ack` stays 0.
- CPU and DMA request together, repeated four times → grants alternate CPU, DMA, CPU, DMA. `owner` matches each `dev_en` window.
- DMA write to 0x000004, device never acks, TIMEOUT = 15 → `dev_en` high for exactly 15 cycles, then `dma_ack` and `timeout_err` pulse together. `dma_rdata` is unchanged.
- CPU read that times out → `cpu_rdata` = 0xFFFFFF with `cpu_ack`. A later good read returns the device data.
- `rst` asserted for one cycle mid-WAIT → all outputs 0 next cycle, no ack pulse. A fresh request afterwards is granted to the CPU on a tie.
- Stray `dev_ack` in IDLE, and CPU holding `cpu_en` for one cycle after its ack → no spurious ack and no second grant.

Source files
------------

// File: rtl/mmio_arb_pkg.sv
// Shared types and constants for the MMIO bus arbiter.
package mmio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Wide enough for any supported data width; sliced down at the use site.
  localparam logic [63:0] ERR_DATA = '1;

  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/mmio_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not go last wins.
module rr_pick2
  import mmio_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);

  // req[0] is the CPU, req[1] the DMA; with a single requester it simply wins.
  always_comb begin
    win = OWN_CPU;
    if (req == 2'b11) win = ~last;
    else              win = req[1];
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Arbitrates CPU and DMA access to the shared MMIO bus, with an ack watchdog.
//
//  state | meaning
//  IDLE  | no transaction, waiting for a request
//  WAIT  | dev_en high, waiting for dev_ack or the watchdog
//  DONE  | one cycle after completion, requests ignored
module mmio_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic              cpu_iorw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_en,
  input  logic              dma_iorw,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              dev_en,
  output logic              dev_iorw,
  output logic [ADDR_W-1:0] dev_addr,
  output logic [DATA_W-1:0] dev_wdata,
  input  logic [DATA_W-1:0] dev_rdata,
  input  logic              dev_ack,
  output logic              owner,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ERR_RD   = ERR_DATA[DATA_W-1:0];

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        last_owner;
  logic        win;
  logic        grant, fin, to_fire;
  logic [DATA_W-1:0] rd_val;

  rr_pick2 u_pick (
    .req  ({dma_en, cpu_en}),
    .last (last_owner),
    .win  (win)
  );

  assign dev_en = (state == WAIT);
  assign busy   = (state != IDLE);
  assign rd_val = to_fire ? ERR_RD : dev_rdata;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the grant/finish/timeout strobes for the datapath.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    fin       = 1'b0;
    to_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_en || dma_en) begin
          grant     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // An ack on the last watchdog cycle wins over the timeout.
        if (dev_ack) begin
          fin       = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          fin       = 1'b1;
          to_fire   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, watchdog counter, completion pulses and read-data return.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      last_owner  <= OWN_DMA;
      owner       <= OWN_CPU;
      dev_iorw    <= 1'b0;
      dev_addr    <= '0;
      dev_wdata   <= '0;
      cpu_rdata   <= '0;
      dma_rdata   <= '0;
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cpu_ack     <= 1'b0;
      dma_ack     <= 1'b0;
      timeout_err <= 1'b0;
      if (grant) begin
        owner      <= win;
        last_owner <= win;
        cnt        <= '0;
        dev_iorw   <= (win == OWN_DMA) ? dma_iorw  : cpu_iorw;
        dev_addr   <= (win == OWN_DMA) ? dma_addr  : cpu_addr;
        dev_wdata  <= (win == OWN_DMA) ? dma_wdata : cpu_wdata;
      end else if (state == WAIT && !fin) begin
        cnt <= cnt + 8'd1;
      end
      if (fin) begin
        timeout_err <= to_fire;
        if (owner == OWN_CPU) begin
          cpu_ack <= 1'b1;
          if (dev_iorw) cpu_rdata <= rd_val;
        end else begin
          dma_ack <= 1'b1;
          if (dev_iorw) dma_rdata <= rd_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter with hand-computed expectations.
module tb_mmio_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en, cpu_iorw;
  logic [23:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        dma_en, dma_iorw;
  logic [23:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack;
  logic        dev_en, dev_iorw;
  logic [23:0] dev_addr, dev_wdata, dev_rdata;
  logic        dev_ack;
  logic        owner, busy, timeout_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_en;

  mmio_arbiter #(.DATA_W(24), .ADDR_W(24), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_iorw(cpu_iorw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_en(dma_en), .dma_iorw(dma_iorw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .dev_en(dev_en), .dev_iorw(dev_iorw), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_rdata(dev_rdata), .dev_ack(dev_ack),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_en = 1'b0; cpu_iorw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_en = 1'b0; dma_iorw = 1'b0; dma_addr = '0; dma_wdata = '0;
    dev_ack = 1'b0; dev_rdata = '0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  // Called while dev_en is high; returns how many cycles it stays high (bounded).
  task automatic count_en(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!dev_en) break;
      n++;
      cyc();
    end
  endtask

  initial begin
    do_reset();
    chk("rst_busy",   32'(busy), 0);
    chk("rst_owner",  32'(owner), 0);
    chk("rst_dev_en", 32'(dev_en), 0);
    chk("rst_cpu_rd", 32'(cpu_rdata), 0);
    chk("rst_dma_rd", 32'(dma_rdata), 0);
    chk("rst_dev_ad", 32'(dev_addr), 0);

    // CPU read, device acks in the second dev_en cycle.
    cpu_en = 1'b1; cpu_iorw = 1'b1; cpu_addr = 24'h00000C;
    cyc();
    chk("rd_dev_en", 32'(dev_en), 1);
    chk("rd_busy",   32'(busy), 1);
    chk("rd_owner",  32'(owner), 0);
    chk("rd_addr",   32'(dev_addr), 32'h00000C);
    chk("rd_iorw",   32'(dev_iorw), 1);
    cyc();
    dev_ack = 1'b1; dev_rdata = 24'h8A4F1B;
    cyc();
    chk("rd_cpu_ack", 32'(cpu_ack), 1);
    chk("rd_cpu_dat", 32'(cpu_rdata), 32'h8A4F1B);
    chk("rd_dma_ack", 32'(dma_ack), 0);
    chk("rd_dev_off", 32'(dev_en), 0);
    cpu_en = 1'b0; dev_ack = 1'b0;
    cyc();
    chk("rd_ack_1cy", 32'(cpu_ack), 0);
    chk("rd_idle",    32'(busy), 0);

    // Four ties in a row alternate CPU, DMA, CPU, DMA from reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cpu_en = 1'b1; cpu_iorw = 1'b1; cpu_addr = 24'h000100;
      dma_en = 1'b1; dma_iorw = 1'b1; dma_addr = 24'h000200;
      cyc();
      chk($sformatf("tie%0d_en", i),    32'(dev_en), 1);
      chk($sformatf("tie%0d_owner", i), 32'(owner), 32'(i % 2));
      chk($sformatf("tie%0d_addr", i),  32'(dev_addr), (i % 2 == 0) ? 32'h100 : 32'h200);
      dev_ack = 1'b1; dev_rdata = 24'h100000 + 24'(i);
      cyc();
      chk($sformatf("tie%0d_cack", i), 32'(cpu_ack), (i % 2 == 0) ? 1 : 0);
      chk($sformatf("tie%0d_dack", i), 32'(dma_ack), (i % 2 == 1) ? 1 : 0);
      dev_ack = 1'b0;
      if (i % 2 == 0) cpu_en = 1'b0; else dma_en = 1'b0;
      cyc();
    end
    chk("tie_cpu_rd", 32'(cpu_rdata), 32'h100002);
    chk("tie_dma_rd", 32'(dma_rdata), 32'h100003);
    cpu_en = 1'b0; dma_en = 1'b0;

    // DMA write that never gets acked: watchdog fires after exactly 15 cycles.
    dma_en = 1'b1; dma_iorw = 1'b0; dma_addr = 24'h000004; dma_wdata = 24'h123456;
    cyc();
    chk("to_w_owner", 32'(owner), 1);
    chk("to_w_wdata", 32'(dev_wdata), 32'h123456);
    chk("to_w_iorw",  32'(dev_iorw), 0);
    count_en(n_en);
    chk("to_w_len",   32'(n_en), 15);
    chk("to_w_dack",  32'(dma_ack), 1);
    chk("to_w_err",   32'(timeout_err), 1);
    chk("to_w_cack",  32'(cpu_ack), 0);
    chk("to_w_rdata", 32'(dma_rdata), 32'h100003);
    dma_en = 1'b0;
    cyc();
    chk("to_w_err_1", 32'(timeout_err), 0);

    // CPU read that times out returns all ones.
    cpu_en = 1'b1; cpu_iorw = 1'b1; cpu_addr = 24'h000010;
    cyc();
    count_en(n_en);
    chk("to_r_len",   32'(n_en), 15);
    chk("to_r_ack",   32'(cpu_ack), 1);
    chk("to_r_err",   32'(timeout_err), 1);
    chk("to_r_rdata", 32'(cpu_rdata), 32'hFFFFFF);
    cpu_en = 1'b0;
    cyc();

    // Following good read returns device data.
    cpu_en = 1'b1;
    cyc();
    dev_ack = 1'b1; dev_rdata = 24'h5A5A5A;
    cyc();
    chk("good_ack",   32'(cpu_ack), 1);
    chk("good_rdata", 32'(cpu_rdata), 32'h5A5A5A);
    chk("good_err",   32'(timeout_err), 0);
    cpu_en = 1'b0; dev_ack = 1'b0;
    cyc();

    // Ack arriving on the final watchdog cycle is a normal completion.
    cpu_en = 1'b1;
    cyc();
    repeat (14) cyc();
    chk("edge_en", 32'(dev_en), 1);
    dev_ack = 1'b1; dev_rdata = 24'h0F0F0F;
    cyc();
    chk("edge_ack",   32'(cpu_ack), 1);
    chk("edge_err",   32'(timeout_err), 0);
    chk("edge_rdata", 32'(cpu_rdata), 32'h0F0F0F);
    cpu_en = 1'b0; dev_ack = 1'b0;
    cyc();

    // Reset in the middle of WAIT: everything clears, no ack.
    cpu_en = 1'b1; cpu_addr = 24'h000020;
    cyc(); cyc();
    chk("mid_en", 32'(dev_en), 1);
    rst = 1'b1; cpu_en = 1'b0;
    cyc();
    rst = 1'b0;
    chk("mid_dev_en", 32'(dev_en), 0);
    chk("mid_busy",   32'(busy), 0);
    chk("mid_ack",    32'(cpu_ack), 0);
    chk("mid_err",    32'(timeout_err), 0);
    chk("mid_rdata",  32'(cpu_rdata), 0);
    chk("mid_addr",   32'(dev_addr), 0);
    cyc();
    chk("mid_ack_2",  32'(cpu_ack), 0);
    cpu_en = 1'b1; dma_en = 1'b1; dma_iorw = 1'b1;
    cyc();
    chk("mid_tie_owner", 32'(owner), 0);
    dev_ack = 1'b1; dev_rdata = 24'h000777;
    cyc();
    chk("mid_tie_ack", 32'(cpu_ack), 1);
    cpu_en = 1'b0; dma_en = 1'b0; dev_ack = 1'b0;
    cyc();

    // Stray dev_ack in IDLE does nothing.
    dev_ack = 1'b1; dev_rdata = 24'hABCDEF;
    cyc();
    chk("stray_cack", 32'(cpu_ack), 0);
    chk("stray_dack", 32'(dma_ack), 0);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_rd",   32'(cpu_rdata), 32'h000777);
    dev_ack = 1'b0;

    // CPU keeps cpu_en one cycle past its ack (and dev_ack lingers): no re-grant.
    cpu_en = 1'b1; cpu_iorw = 1'b1;
    cyc();
    dev_ack = 1'b1; dev_rdata = 24'h00BEEF;
    cyc();
    chk("hold_ack", 32'(cpu_ack), 1);
    cyc();
    chk("hold_busy",  32'(busy), 0);
    chk("hold_ack_2", 32'(cpu_ack), 0);
    cpu_en = 1'b0; dev_ack = 1'b0;
    cyc();
    chk("hold_idle", 32'(dev_en), 0);
    chk("hold_ack_3", 32'(cpu_ack), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
